// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath widths, default reset vector
// and the fetch FSM state type.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 16;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sign_extend.sv
// Generic sign extender: replicates the input MSB into the upper output bits.
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    assign dout = {{(OUT_W - IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it until consumed,
// then redirects. Optional misalignment trap under FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jr,
    input  logic [XLEN-1:0] jr_target,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] imm_ext,
    output logic            misalign
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] instr_next;
    logic            valid_next;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;

    sign_extend #(
        .IN_W  (IMM_W),
        .OUT_W (XLEN)
    ) u_sign_extend (
        .din  (instr[IMM_W-1:0]),
        .dout (imm_ext)
    );

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        if (jr)
            target_raw = jr_target;
        else if (jump)
            target_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch_taken)
            target_raw = pc_plus4 + (imm_ext << 2);
        else
            target_raw = pc_plus4;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign target   = target_raw;
    assign misalign = (state == FAULT);
`else
    // Only jr can produce a misaligned target; without the trap it is rounded down.
    assign target   = target_raw & ~32'd3;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        valid_next = instr_valid;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    valid_next = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (target[1:0] != 2'b00) begin
                        state_next = FAULT;
                    end else begin
                        pc_next    = target;
                        state_next = REQ;
                    end
`else
                    pc_next    = target;
                    state_next = REQ;
`endif
                end
            end
            FAULT: valid_next = 1'b0;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_valid <= valid_next;
        end
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign pc_out    = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reset/startup, redirect vectors,
// wait states, stalls, randomized fetch stream and the misalignment case.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic        misalign;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .imm_ext      (imm_ext),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        br;
        logic        jmp;
        logic        jreg;
        logic [31:0] tgt;
        logic [31:0] exp_imm;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural next-pc rule: jr > jump > branch > sequential, word aligned.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic br, input logic jmp, input logic jreg,
                                               input logic [31:0] tgt);
        logic [31:0] p4;
        logic [31:0] imm;
        logic [31:0] n;
        p4  = pc + 32'd4;
        imm = {{16{word[15]}}, word[15:0]};
        if (jreg)     n = tgt;
        else if (jmp) n = {p4[31:28], word[25:0], 2'b00};
        else if (br)  n = p4 + imm * 4;
        else          n = p4;
        return n & ~32'd3;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 10) begin
            step();
            n++;
        end
        if (!imem_req) check_output("req_timeout", 32'(imem_req), 32'd1);
    endtask

    // Serve one request at exp_addr after 'delay' wait states, junk on ignored inputs meanwhile.
    task automatic do_fetch(input logic [31:0] rdata, input int delay, input logic [31:0] exp_addr);
        wait_req();
        check_output("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            imem_ack  = 1'b0;
            stall     = 1'($urandom);
            jr        = 1'($urandom);
            jr_target = $urandom;
            step();
            check_output("wait_req", 32'(imem_req), 32'd1);
            check_output("wait_addr", imem_addr, exp_addr);
        end
        stall      = 1'b0;
        jr         = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check_output("instr_valid", 32'(instr_valid), 32'd1);
        check_output("instr", instr, rdata);
        check_output("pc_out", pc_out, exp_addr);
        check_output("pc_plus4", pc_plus4, exp_addr + 32'd4);
        check_output("hold_req", 32'(imem_req), 32'd0);
    endtask

    // Hold for n stall cycles, then release with the given redirect.
    task automatic apply_stimulus(input int n, input logic br, input logic jmp, input logic jreg,
                                  input logic [31:0] tgt, input logic [31:0] held_instr,
                                  input logic [31:0] held_pc);
        for (int i = 0; i < n; i++) begin
            stall = 1'b1;
            step();
            check_output("stall_valid", 32'(instr_valid), 32'd1);
            check_output("stall_instr", instr, held_instr);
            check_output("stall_pc", pc_out, held_pc);
            check_output("stall_req", 32'(imem_req), 32'd0);
        end
        stall        = 1'b0;
        branch_taken = br;
        jump         = jmp;
        jr           = jreg;
        jr_target    = tgt;
        step();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] rd;
        logic        rb, rj, rr;
        logic [31:0] rt;
        logic        exp_req[6];
        logic [31:0] exp_addr6[6];
        logic        exp_val[6];

        vecs[0] = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'h0000_000C};
        vecs[1] = '{32'h0000_0010, 32'h1000_0002, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0002, 32'h0000_001C};
        vecs[2] = '{32'h0000_0020, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h100, 32'h0000_0040, 32'h0000_0100};
        vecs[3] = '{32'h9000_0000, 32'h0A00_0010, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0010, 32'h9800_0040};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'hFFFF_FFF0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0004};
        vecs[6] = '{32'h0000_0040, 32'h1234_8000, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_8000, 32'h0000_0044};
        vecs[7] = '{32'h0000_0040, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h204, 32'h0000_0000, 32'h0000_0204};

        rst_n        = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        jr_target    = 32'h0;

        // Reset state, with ack already high (must be ignored).
        step();
        step();
        check_output("rst_req", 32'(imem_req), 32'd0);
        check_output("rst_valid", 32'(instr_valid), 32'd0);
        check_output("rst_instr", instr, 32'd0);
        check_output("rst_pc", pc_out, 32'd0);
        check_output("rst_misalign", 32'(misalign), 32'd0);

        // Startup with ack tied high: IDLE, then fetches at 0, 4, 8 every second cycle.
        exp_req   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr6 = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        exp_val   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            check_output($sformatf("start_req%0d", i), 32'(imem_req), 32'(exp_req[i]));
            check_output($sformatf("start_addr%0d", i), imem_addr, exp_addr6[i]);
            check_output($sformatf("start_valid%0d", i), 32'(instr_valid), 32'(exp_val[i]));
        end
        imem_ack = 1'b0;
        cur_pc   = 32'h8;

        // Wait states then asynchronous reset mid-request.
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("ws_req", 32'(imem_req), 32'd1);
            check_output("ws_addr", imem_addr, cur_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        check_output("async_req", 32'(imem_req), 32'd0);
        check_output("async_pc", pc_out, 32'd0);
        check_output("async_valid", 32'(instr_valid), 32'd0);
        step();
        rst_n = 1'b1;
        check_output("restart_idle", 32'(imem_req), 32'd0);
        step();
        check_output("restart_req", 32'(imem_req), 32'd1);
        check_output("restart_addr", imem_addr, 32'd0);
        cur_pc = 32'h0;

        // Reset while holding an instruction.
        do_fetch(32'h1111_2222, 1, cur_pc);
        #2 rst_n = 1'b0;
        #1;
        check_output("hold_rst_valid", 32'(instr_valid), 32'd0);
        check_output("hold_rst_instr", instr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        cur_pc = 32'h0;

        // Redirect vectors: steer pc with a jr, then fetch the vector's word.
        for (int v = 0; v < 8; v++) begin
            do_fetch(32'h0, 0, cur_pc);
            apply_stimulus(0, 1'b0, 1'b0, 1'b1, vecs[v].pc, 32'h0, cur_pc);
            do_fetch(vecs[v].word, 0, vecs[v].pc);
            check_output($sformatf("vec%0d_imm", v), imm_ext, vecs[v].exp_imm);
            apply_stimulus(0, vecs[v].br, vecs[v].jmp, vecs[v].jreg, vecs[v].tgt,
                           vecs[v].word, vecs[v].pc);
            check_output($sformatf("vec%0d_req", v), 32'(imem_req), 32'd1);
            check_output($sformatf("vec%0d_next", v), imem_addr, vecs[v].exp_next);
            cur_pc = vecs[v].exp_next;
        end

        // Five-cycle stall: nothing moves, fetch resumes one cycle after release.
        do_fetch(32'hCAFE_0001, 0, cur_pc);
        apply_stimulus(5, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE_0001, cur_pc);
        check_output("stall_resume_req", 32'(imem_req), 32'd1);
        check_output("stall_resume_addr", imem_addr, cur_pc + 32'd4);
        cur_pc = cur_pc + 32'd4;

        // Randomized fetch stream against the architectural model.
        for (int k = 0; k < 150; k++) begin
            rd = $urandom;
            do_fetch(rd, int'($urandom_range(0, 3)), cur_pc);
            rb = 1'($urandom);
            rj = 1'($urandom);
            rr = 1'($urandom_range(0, 3) == 0);
            rt = $urandom & ~32'd3;
            apply_stimulus(int'($urandom_range(0, 2)), rb, rj, rr, rt, rd, cur_pc);
            cur_pc = model_next(cur_pc, rd, rb, rj, rr, rt);
        end

        // Misaligned jr target.
        do_fetch(32'h0, 0, cur_pc);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0, cur_pc);
`ifdef FETCH_ALIGN_CHECK_EN
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_output("fault_misalign", 32'(misalign), 32'd1);
            check_output("fault_req", 32'(imem_req), 32'd0);
            check_output("fault_valid", 32'(instr_valid), 32'd0);
            step();
        end
        imem_ack = 1'b0;
`else
        check_output("noalign_misalign", 32'(misalign), 32'd0);
        check_output("noalign_req", 32'(imem_req), 32'd1);
        check_output("noalign_addr", imem_addr, 32'h100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
